ps2_scancode_decoder: RTL
=========================

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, 50 MHz, all state on rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: code  in  8  raw PS/2 set-2 byte from the keyboard stage, valid while int=1.
REQ-004 SHALL have: int  in  1  byte-available flag from the keyboard stage; held until acknowledged.
REQ-005 SHALL have: intAck  out  1  acknowledge to the keyboard stage.
REQ-006 SHALL have: ev_valid  out  1  event FIFO non-empty.
REQ-007 SHALL have: ev_data  out  10  head event {ext, brk, code[7:0]}, first-word-fall-through.
REQ-008 SHALL have: ev_rd  in  1  pop head event; ignored when ev_valid=0.
REQ-009 SHALL have: shift, ctrl, alt  out  1 each  live modifier levels.
REQ-010 SHALL have: ev_overflow  out  1  sticky, event dropped on full FIFO.
REQ-011 SHALL have parameter: FIFO_DEPTH, default 4, power of two >= 2.

Function
REQ-012 Handshake SHALL be a two-state machine: IDLE -> ACK when int=1 (code captured that edge); ACK holds intAck=1 until int=0 sampled, then -> IDLE with intAck=0.
REQ-013 intAck SHALL be registered; first assertion one cycle after int sampled high; each byte SHALL be consumed exactly once.
REQ-014 Byte 0xE0 SHALL set ext_pend, emit nothing.
REQ-015 Byte 0xF0 SHALL set brk_pend, emit nothing.
REQ-016 Byte 0xE1 SHALL load a 3-bit skip counter with 7, clear pending flags; the next 7 bytes SHALL be discarded; on the 7th, one event {1,0,0xE1} SHALL be pushed.
REQ-017 Bytes 0x00, 0xFF, 0xAA, 0xFA, 0xFE SHALL be discarded and clear ext_pend/brk_pend.
REQ-018 Any other byte SHALL push {ext_pend, brk_pend, byte} and clear both flags in the same cycle.
REQ-019 Modifiers SHALL update on every decoded key byte, independent of FIFO state: shift<-~brk for 0x12/0x59 (ext=0); ctrl<-~brk for 0x14 (either ext); alt<-~brk for 0x11 (either ext).
REQ-020 Decode and push SHALL occur on the IDLE->ACK edge; event visible on ev_valid/ev_data one cycle after int is sampled.
REQ-021 Push on full without simultaneous pop SHALL drop the event and set ev_overflow; ev_overflow clears only on rst.
REQ-022 Simultaneous push and pop on full SHALL succeed with no overflow; on empty, push wins and pop is ignored.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL use one extra bit to distinguish full/empty.

Reset
REQ-024 On rst: state=IDLE, intAck=0, FIFO empty (ev_valid=0, ev_data=0), shift=ctrl=alt=0, ev_overflow=0, pending flags and skip counter=0.
REQ-025 rst mid-ACK or mid-E1 sequence SHALL abandon it; the next int=1 after release SHALL be treated as a fresh byte.

Structure
REQ-026 Scan-code constants (E0, F0, E1, modifier codes, discard set) and the event field layout SHALL live in a shared package ps2_pkg.
REQ-027 The FIFO SHALL be a sub-module event_fifo (width 10, depth FIFO_DEPTH, FWFT, same clk/rst).

Verification
REQ-028 Bytes 0x1C -> one event 0x01C; intAck high until int drops; ev_valid=1 one cycle after int.
REQ-029 Bytes E0,F0,75 -> single event 0x375; no events for prefixes.
REQ-030 Bytes 12 then F0,12 -> shift=1 after first byte, shift=0 after 0x12 release; events 0x012, 0x112.
REQ-031 Sequence E1,14,77,E1,F0,14,F0,77 -> exactly one event 0x2E1.
REQ-032 Five key bytes, no ev_rd -> 4 events held, ev_overflow=1; then ev_rd with sixth push on full -> no new overflow drop, order preserved.
REQ-033 rst asserted while intAck=1 -> intAck=0, ev_valid=0, modifiers 0 immediately (asynchronous).

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : PS/2 set-2 scan-code constants and decoded event layout.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] c_code_ext    = 8'hE0;
    localparam logic [7:0] c_code_brk    = 8'hF0;
    localparam logic [7:0] c_code_pause  = 8'hE1;
    localparam logic [7:0] c_code_lshift = 8'h12;
    localparam logic [7:0] c_code_rshift = 8'h59;
    localparam logic [7:0] c_code_ctrl   = 8'h14;
    localparam logic [7:0] c_code_alt    = 8'h11;

    // Bytes that follow 0xE1 in the Pause sequence and are swallowed.
    localparam logic [2:0] c_pause_skip  = 3'd7;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] scan;
    } ps2_event_t;

    localparam int c_event_w = $bits(ps2_event_t);

    function automatic logic is_discard(input logic [7:0] b);
        return (b inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE});
    endfunction

endpackage
`default_nettype wire

// File: rtl/event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : event_fifo
// Description : First-word-fall-through event FIFO with sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_overflow;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A pop on full frees the slot the simultaneous push lands in.
    assign w_pop   = pop && !w_empty;
    assign w_push  = push && (!w_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (push && !w_push) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

    assign valid    = !w_empty;
    assign data     = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scancode_decoder
// Description : PS/2 set-2 byte handshake, prefix decode, modifiers, event FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           code,
    input  logic                 int_flag,
    output logic                 intAck,
    output logic                 ev_valid,
    output logic [c_event_w-1:0] ev_data,
    input  logic                 ev_rd,
    output logic                 shift,
    output logic                 ctrl,
    output logic                 alt,
    output logic                 ev_overflow
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_ack  = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_next;
    logic       w_decode;
    logic       r_ext;
    logic       r_brk;
    logic [2:0] r_skip;
    logic       r_shift;
    logic       r_ctrl;
    logic       r_alt;
    logic       w_push;
    logic       w_key;
    ps2_event_t w_event;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (int_flag)  w_state_next = c_st_ack;
            c_st_ack:  if (!int_flag) w_state_next = c_st_idle;
            default:                  w_state_next = c_st_idle;
        endcase
    end

    // The byte is consumed only on the IDLE->ACK edge, so a held int is seen once.
    always_comb begin
        intAck   = (r_state == c_st_ack);
        w_decode = (r_state == c_st_idle) && int_flag;
    end

    always_comb begin
        w_push  = 1'b0;
        w_key   = 1'b0;
        w_event = '0;
        if (w_decode) begin
            if (r_skip != 3'd0) begin
                if (r_skip == 3'd1) begin
                    w_push  = 1'b1;
                    w_event = ps2_event_t'{ext: 1'b1, brk: 1'b0, scan: c_code_pause};
                end
            end else if (!(code inside {c_code_ext, c_code_brk, c_code_pause}) &&
                         !is_discard(code)) begin
                w_key   = 1'b1;
                w_push  = 1'b1;
                w_event = ps2_event_t'{ext: r_ext, brk: r_brk, scan: code};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_skip <= 3'd0;
        end else if (w_decode) begin
            if (r_skip != 3'd0) begin
                r_skip <= r_skip - 3'd1;
            end else begin
                case (code)
                    c_code_ext: r_ext <= 1'b1;
                    c_code_brk: r_brk <= 1'b1;
                    c_code_pause: begin
                        r_skip <= c_pause_skip;
                        r_ext  <= 1'b0;
                        r_brk  <= 1'b0;
                    end
                    default: begin
                        r_ext <= 1'b0;
                        r_brk <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= 1'b0;
            r_ctrl  <= 1'b0;
            r_alt   <= 1'b0;
        end else if (w_key) begin
            if (!r_ext && (code == c_code_lshift || code == c_code_rshift)) r_shift <= !r_brk;
            if (code == c_code_ctrl) r_ctrl <= !r_brk;
            if (code == c_code_alt)  r_alt  <= !r_brk;
        end
    end

    assign shift = r_shift;
    assign ctrl  = r_ctrl;
    assign alt   = r_alt;

    event_fifo #(
        .WIDTH (c_event_w),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_event),
        .pop       (ev_rd),
        .valid     (ev_valid),
        .data      (ev_data),
        .overflow  (ev_overflow)
    );

endmodule
`default_nettype wire
